// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, fixed-priority interrupt controller driving the PC irq and tracking service via PC31.
// Define IRQ_SYNC_EN to pass src through a 2-flop synchronizer before edge detection.
module irq_ctrl #(
    parameter int NSRC = 8,
    localparam int IDW = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            PC31,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    output logic            irq,
    output logic [IDW-1:0]  cause_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
    state_t          r_state;
    logic [NSRC-1:0] r_src_d, r_pending, r_mask;
    logic [NSRC-1:0] w_s, w_set, w_clr, w_act;
    logic [IDW-1:0]  r_cause_id, w_win;
    logic            r_irq, r_in_service, r_pc31_q, w_take;
`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] r_sync1, r_sync2;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end
    assign w_s = r_sync2;
`else
    assign w_s = src;
`endif
    assign w_act  = r_pending & r_mask;
    assign w_set  = w_s & ~r_src_d;
    assign w_take = (r_state == REQ) && !PC31;
    // A fresh edge on the bit being taken wins over the take-clear.
    assign w_clr  = w_take ? (NSRC'(1) << r_cause_id) : '0;
    always_comb begin
        w_win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_act[i]) w_win = IDW'(i);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_src_d      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_cause_id   <= '0;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
            r_pc31_q     <= 1'b0;
        end else begin
            r_src_d   <= w_s;
            r_pc31_q  <= PC31;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (mask_we) r_mask <= mask_wdata;
            case (r_state)
                IDLE: if (|w_act && !PC31) begin
                    r_cause_id <= w_win;
                    r_irq      <= 1'b1;
                    r_state    <= REQ;
                end
                REQ: if (!PC31) begin
                    r_irq        <= 1'b0;
                    r_in_service <= 1'b1;
                    r_state      <= SVC;
                end
                SVC: if (r_pc31_q && !PC31) begin
                    r_in_service <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign irq        = r_irq;
    assign cause_id   = r_cause_id;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl; expectations are queued with each stimulus step
// and compared against the outputs sampled 1 time unit after the following clock edge.
module tb_irq_ctrl;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int S_IRQ = 0, S_CID = 1, S_INS = 2, S_PEND = 3, S_MASK = 4;
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset, PC31, mask_we, irq, in_service;
    logic [7:0] src, mask_wdata, pending, mask;
    logic [2:0] cause_id;
    exp_t       sb[$];
    int         n_cmp = 0, n_bad = 0;

    irq_ctrl #(.NSRC(8)) dut (
        .clk(clk), .reset(reset), .src(src), .PC31(PC31),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .irq(irq),
        .cause_id(cause_id), .in_service(in_service),
        .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, req, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_IRQ:   return {31'd0, irq};
            S_CID:   return {29'd0, cause_id};
            S_INS:   return {31'd0, in_service};
            S_PEND:  return {24'd0, pending};
            default: return {24'd0, mask};
        endcase
    endfunction

    task automatic expect_next(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic write_mask(input logic [7:0] m, input string tag);
        mask_we = 1'b1;
        mask_wdata = m;
        expect_next(tag, S_MASK, {24'd0, m});
        step();
        mask_we = 1'b0;
    endtask

    task automatic handler_return(input string tag);
        PC31 = 1'b1;
        step();
        PC31 = 1'b0;
        expect_next({tag, "_ins"}, S_INS, 0);
        expect_next({tag, "_irq"}, S_IRQ, 0);
        step();
    endtask

    // Drive src for one sampled edge (plus synchronizer delay) and expect pending afterwards.
    task automatic pulse(input logic [7:0] s, input logic [7:0] pend, input string tag);
        src = s;
        for (int k = 0; k < LAT; k++) begin
            if (k == 0) src = s;
            step();
        end
        expect_next(tag, S_PEND, {24'd0, pend});
        step();
        src = 8'h00;
    endtask

    initial begin
        reset = 1'b0; src = 8'hFF; PC31 = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
        step();
        expect_next("rst_irq", S_IRQ, 0);
        expect_next("rst_pend", S_PEND, 0);
        expect_next("rst_mask", S_MASK, 0);
        expect_next("rst_cid", S_CID, 0);
        expect_next("rst_ins", S_INS, 0);
        step();
        src = 8'h00;
        step();
        reset = 1'b1;

        write_mask(8'h08, "single_mask");
        pulse(8'h08, 8'h08, "single_pend");
        expect_next("single_irq", S_IRQ, 1);
        expect_next("single_cid", S_CID, 3);
        step();
        expect_next("single_take_irq", S_IRQ, 0);
        expect_next("single_take_ins", S_INS, 1);
        expect_next("single_take_pend", S_PEND, 0);
        step();
        handler_return("single_ret");

        write_mask(8'hFF, "prio_mask");
        pulse(8'h24, 8'h24, "prio_pend");
        expect_next("prio_irq", S_IRQ, 1);
        expect_next("prio_cid2", S_CID, 2);
        step();
        expect_next("prio_take_ins", S_INS, 1);
        expect_next("prio_take_pend", S_PEND, 8'h20);
        step();
        handler_return("prio_ret");
        expect_next("prio_irq5", S_IRQ, 1);
        expect_next("prio_cid5", S_CID, 5);
        step();
        expect_next("prio_take5_pend", S_PEND, 0);
        expect_next("prio_take5_ins", S_INS, 1);
        step();
        handler_return("prio_ret5");

        pulse(8'h10, 8'h10, "hold_pend");
        expect_next("hold_irq", S_IRQ, 1);
        expect_next("hold_cid", S_CID, 4);
        step();
        PC31 = 1'b1;
        src = 8'h01;
        for (int k = 0; k < 5; k++) begin
            expect_next("hold_irq_k", S_IRQ, 1);
            expect_next("hold_cid_k", S_CID, 4);
            if (k == 4) expect_next("hold_pend_both", S_PEND, 8'h11);
            step();
            src = 8'h00;
        end
        PC31 = 1'b0;
        expect_next("hold_take_irq", S_IRQ, 0);
        expect_next("hold_take_cid", S_CID, 4);
        expect_next("hold_take_pend", S_PEND, 8'h01);
        step();
        handler_return("hold_ret");
        expect_next("hold_irq0", S_IRQ, 1);
        expect_next("hold_cid0", S_CID, 0);
        step();
        expect_next("hold_take0_pend", S_PEND, 0);
        step();
        handler_return("hold_ret0");

        write_mask(8'h00, "mask_clear");
        pulse(8'h02, 8'h02, "mask_pend");
        for (int k = 0; k < 2; k++) begin
            expect_next("mask_noirq", S_IRQ, 0);
            expect_next("mask_keep_pend", S_PEND, 8'h02);
            step();
        end
        expect_next("mask_oldmask_irq", S_IRQ, 0);
        write_mask(8'h02, "mask_set");
        expect_next("mask_irq", S_IRQ, 1);
        expect_next("mask_cid", S_CID, 1);
        step();
        expect_next("mask_take_pend", S_PEND, 0);
        step();
        handler_return("mask_ret");

        write_mask(8'hFF, "sim_mask");
        pulse(8'h08, 8'h08, "sim_pend");
        expect_next("sim_cid", S_CID, 3);
        step();
        PC31 = 1'b1;
        src = 8'h08;
        for (int k = 0; k < LAT; k++) step();
        PC31 = 1'b0;
        expect_next("sim_take_ins", S_INS, 1);
        expect_next("sim_setwins_pend", S_PEND, 8'h08);
        step();
        src = 8'h00;
        handler_return("sim_ret");
        expect_next("sim_rereq_irq", S_IRQ, 1);
        expect_next("sim_rereq_cid", S_CID, 3);
        step();
        expect_next("svc_ins", S_INS, 1);
        step();

        reset = 1'b0;
        expect_next("svcrst_ins", S_INS, 0);
        expect_next("svcrst_irq", S_IRQ, 0);
        expect_next("svcrst_pend", S_PEND, 0);
        expect_next("svcrst_mask", S_MASK, 0);
        step();
        reset = 1'b1;
        step();
        expect_next("post_rst_irq", S_IRQ, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
